// File: rtl/matrix_multiplier_axis.sv
// matrix_multiplier_axis
//   Runtime-sized N x N signed matrix multiplier. A then B arrive row-major on
//   the slave stream (2*N^2 beats). C = A*B is built with one MAC unit, and C
//   then leaves row-major on the master stream (N^2 beats).
// Ports:
//   CLK, RESET        clock, async active-low reset
//   DIM               N, sampled on the first accepted beat (0 or >MAX_DIM -> MAX_DIM)
//   S_AXIS_*          input stream (VALID/READY/DATA/LAST)
//   M_AXIS_*          output stream (VALID/READY/DATA/LAST)
//   BUSY              high outside IDLE
//   LAST_ERR          sticky framing error, cleared by the next frame's first beat
module matrix_multiplier_axis #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 8,
  parameter int DIM_W      = $clog2(MAX_DIM+1),
  parameter int ACC_W      = 2*DATA_WIDTH+$clog2(MAX_DIM)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [DIM_W-1:0]             DIM,
  input  logic                         S_AXIS_VALID,
  output logic                         S_AXIS_READY,
  input  logic signed [DATA_WIDTH-1:0] S_AXIS_DATA,
  input  logic                         S_AXIS_LAST,
  output logic                         M_AXIS_VALID,
  input  logic                         M_AXIS_READY,
  output logic signed [ACC_W-1:0]      M_AXIS_DATA,
  output logic                         M_AXIS_LAST,
  output logic                         BUSY,
  output logic                         LAST_ERR
);
  localparam int DEPTH = MAX_DIM*MAX_DIM;
  localparam int AW    = $clog2(DEPTH);
  localparam int NN_W  = AW+1;
  localparam int PW    = 2*DATA_WIDTH;
  localparam logic [DIM_W-1:0] MAXD = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DIM_W-1:0] n, i, j, k, dim_c;
  logic [NN_W-1:0]  nn, cnt;   // cnt: beat index during load and drain
  logic signed [ACC_W-1:0] acc;

  logic signed [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] b_mem [DEPTH];
  logic signed [ACC_W-1:0]      c_mem [DEPTH];

  logic s_hs, m_hs, cnt_last, wr_cyc, last_ij;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign dim_c    = (DIM == '0 || DIM > MAXD) ? MAXD : DIM;
  assign s_hs     = S_AXIS_VALID && S_AXIS_READY;
  assign m_hs     = M_AXIS_VALID && M_AXIS_READY;
  assign cnt_last = (cnt == nn - 1'b1);
  // k == n marks the write-back cycle that follows the N MAC cycles of C[i][j]
  assign wr_cyc   = (state == COMPUTE) && (k == n);
  assign last_ij  = (i == n - 1'b1) && (j == n - 1'b1);

  // Addresses use the runtime stride N so storage stays dense row-major
  assign a_addr   = AW'(i) * AW'(n) + AW'(k);
  assign b_addr   = AW'(k) * AW'(n) + AW'(j);
  assign c_addr   = AW'(i) * AW'(n) + AW'(j);
  assign prod     = a_mem[a_addr] * b_mem[b_addr];
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Ready is gated by reset so it reads 0 while reset is held
  assign S_AXIS_READY = RESET && (state == IDLE || state == LOAD_A || state == LOAD_B);
  assign BUSY         = (state != IDLE);
  assign M_AXIS_VALID = (state == DRAIN);
  assign M_AXIS_DATA  = M_AXIS_VALID ? c_mem[cnt[AW-1:0]] : '0;
  assign M_AXIS_LAST  = M_AXIS_VALID && cnt_last;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_hs) state_nxt = (dim_c == DIM_W'(1)) ? LOAD_B : LOAD_A;
      LOAD_A:  if (s_hs && cnt_last) state_nxt = LOAD_B;
      LOAD_B:  if (s_hs && cnt_last) state_nxt = COMPUTE;
      COMPUTE: if (wr_cyc && last_ij) state_nxt = DRAIN;
      DRAIN:   if (m_hs && cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      n        <= '0;
      nn       <= '0;
      cnt      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      LAST_ERR <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_hs) begin
          n        <= dim_c;
          nn       <= NN_W'(dim_c) * NN_W'(dim_c);
          // with N=1 this beat is all of A, so B starts at index 0
          cnt      <= (dim_c == DIM_W'(1)) ? '0 : NN_W'(1);
          // the first beat can never be beat 2N^2
          LAST_ERR <= S_AXIS_LAST;
        end
        LOAD_A, LOAD_B: if (s_hs) begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (S_AXIS_LAST != (state == LOAD_B && cnt_last)) LAST_ERR <= 1'b1;
          if (state == LOAD_B && cnt_last) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        COMPUTE: begin
          if (wr_cyc) begin
            acc <= '0;
            k   <= '0;
            if (j == n - 1'b1) begin
              j <= '0;
              i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= acc + prod_ext;
            k   <= k + 1'b1;
          end
        end
        DRAIN: if (m_hs) cnt <= cnt_last ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is never cleared; every frame rewrites the entries it uses
  always_ff @(posedge CLK) begin
    if (s_hs && (state == IDLE || state == LOAD_A)) a_mem[cnt[AW-1:0]] <= S_AXIS_DATA;
    if (s_hs && state == LOAD_B) b_mem[cnt[AW-1:0]] <= S_AXIS_DATA;
    if (wr_cyc) c_mem[c_addr] <= acc;
  end
endmodule

// File: doc/matrix_multiplier_axis.md
# matrix_multiplier_axis

Parametrised, runtime-sized square matrix multiplier with AXI-Stream input and output. It accepts two N×N signed matrices A and B on one slave stream, computes C = A·B with a single multiply-accumulate unit into internal C storage, then streams C out on a master stream. This block succeeds the fixed single-bit-stream multiplier shell with:

- configurable data width and maximum dimension,
- a per-transfer dimension,
- framing checks,
- a full load/compute/drain state machine.

## Interface

Parameters:
- DATA_WIDTH, 16, signed element width of A and B.
- MAX_DIM, 8, largest supported N; internal A/B/C storage is MAX_DIM² words each.
- DIM_W, $clog2(MAX_DIM+1), width of DIM port (derived).
- ACC_W, 2*DATA_WIDTH+$clog2(MAX_DIM), signed width of C elements (derived).

Ports:
- CLK  in  1  sole clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- DIM  in  DIM_W  matrix dimension N, sampled on the first accepted input beat.
- S_AXIS_VALID  in  1  input beat valid.
- S_AXIS_READY  out  1  block accepts input beat.
- S_AXIS_DATA  in  DATA_WIDTH  element of A or B, two's complement.
- S_AXIS_LAST  in  1  marks final beat (beat 2N²) of the input frame.
- M_AXIS_VALID  out  1  output beat valid.
- M_AXIS_READY  in  1  downstream accepts output beat.
- M_AXIS_DATA  out  ACC_W  element of C, two's complement.
- M_AXIS_LAST  out  1  marks final C element (beat N²).
- BUSY  out  1  high in any state other than IDLE.
- LAST_ERR  out  1  sticky framing error; cleared at the start of the next frame or by reset.

## Operation

- FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN.
- **IDLE:**
  - S_AXIS_READY=1.
  - On the first handshake, latch N from DIM and clear LAST_ERR.
  - DIM=0 or DIM>MAX_DIM is clamped to MAX_DIM.
  - The accepted beat is A[0][0]; go to LOAD_A (or LOAD_B if N²=1).
- **LOAD_A:**
  - Accept A row-major, N² beats total including the IDLE beat.
  - After beat N², go to LOAD_B.
- **LOAD_B:**
  - Accept B row-major, N² beats.
  - After the final beat (overall beat 2N²), go to COMPUTE.
  - S_AXIS_READY=1 in LOAD_A/LOAD_B and 0 in COMPUTE/DRAIN.
- **Framing:**
  - LAST_ERR sets if S_AXIS_LAST=1 on any beat before 2N².
  - LAST_ERR sets if S_AXIS_LAST=0 on beat 2N².
  - The frame is never truncated or extended: exactly 2N² beats are always consumed.
- **COMPUTE:**
  - For each (i,j) in row-major order:
    - N MAC cycles, acc += A[i][k]·B[k][j] for k=0..N-1;
    - then 1 write cycle storing acc into C[i][j] and clearing acc.
  - Products are full 2·DATA_WIDTH signed, sign-extended to ACC_W.
  - No overflow is possible for N ≤ MAX_DIM, and no truncation is applied.
- **DRAIN:**
  - Stream C row-major, N² beats; M_AXIS_LAST=1 only on beat N².
  - After the last handshake, return to IDLE.
- Storage is not cleared between frames. Each frame fully overwrites the A/B/C entries it uses.

## Timing

- **Reset values** (asynchronous on RESET=0):
  - S_AXIS_READY=0 while RESET=0, then 1 in the first cycle after release (IDLE).
  - M_AXIS_VALID=0, M_AXIS_DATA=0, M_AXIS_LAST=0, BUSY=0, LAST_ERR=0.
  - State=IDLE, all counters and accumulator 0.
- **Input:** a handshake occurs on the rising edge with S_AXIS_VALID && S_AXIS_READY. Full throughput is 1 beat/cycle; VALID gaps are tolerated anywhere.
- **COMPUTE:**
  - Entered the cycle after the final input handshake.
  - Lasts exactly N²·(N+1) cycles.
  - M_AXIS_VALID rises on the following cycle.
- **Output:**
  - M_AXIS_DATA/LAST hold stable while VALID && !READY; VALID never drops without a handshake.
  - Throughput is 1 beat/cycle with READY held high.
- **Return to IDLE:** after the final output handshake, the next cycle is IDLE with S_AXIS_READY=1 and BUSY=0.
- **Latency:** end-to-end from the last input beat to the first output beat is N²·(N+1)+1 cycles.
- **DIM changes:** changes to DIM mid-frame are ignored.
- **Reset mid-operation:** reset in any state aborts the frame immediately, with no partial output beats.

## Test plan

- **2×2 basic:** N=2, A=[1,2,3,4], B=[5,6,7,8], LAST on beat 8 → C out = 19,22,43,50; LAST on beat 4 only; LAST_ERR=0; first output VALID 13 cycles after the last input beat.
- **Signed identity:** N=3, A=identity, B=[-5,2,0,7,-32768,1,3,-1,32767] → C equals B sign-extended to ACC_W.
- **Worst-case magnitude:** N=8 (MAX_DIM), A=B all -32768 → every C element = 2³³ (0x2_0000_0000 in 35 bits); 64 output beats.
- **Backpressure:** N=2 basic vectors, M_AXIS_READY=1,0,0,1,0,1,1 → data held during stalls; sequence 19,22,43,50 unchanged; no duplicates; BUSY drops the cycle after the 4th handshake.
- **Framing errors:**
  - N=2, S_AXIS_LAST on beat 3 and not on beat 8 → LAST_ERR=1 from beat 3; all 8 beats still consumed; C correct.
  - On the next valid frame, LAST_ERR clears at its first beat.
- **Reset mid-compute and DIM clamp:**
  - RESET=0 during COMPUTE → all outputs reset immediately.
  - Then a new frame with DIM=0 (clamped to 8) completes with 128 input / 64 output beats.
